// File: rtl/pipe_mips32_fwd.sv
// Single-clock 5-stage MIPS32 core (IF/ID/EX/MEM/WB) with EX operand forwarding,
// load-use interlock, EX-resolved branches with IF/ID flush, and sticky halt.
module pipe_mips32_fwd #(
  parameter int XLEN = 32,
  parameter int PC_W = 10,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            dmem_we,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            halted,
  output logic            wb_valid,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);
  localparam logic [5:0] OP_ADD  = 6'h00, OP_SUB  = 6'h01, OP_AND  = 6'h02, OP_OR   = 6'h03,
                         OP_SLT  = 6'h04, OP_MUL  = 6'h05, OP_LW   = 6'h08, OP_SW   = 6'h09,
                         OP_ADDI = 6'h0A, OP_SUBI = 6'h0B, OP_SLTI = 6'h0C, OP_BNEQZ = 6'h0D,
                         OP_BEQZ = 6'h0E;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs, rt, dst;
    logic       wr, ld, st, br, hlt, use_rs, use_rt;
  } ctl_t;

  typedef struct packed {
    logic [5:0]      op;
    logic [4:0]      rs, rt, dst;
    logic            wr, ld, st, br, hlt;
    logic [PC_W-1:0] npc;
    logic [XLEN-1:0] a, b, imm;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0] alu, b;
    logic [4:0]      dst;
    logic            wr, ld, st, hlt;
  } ex_mem_t;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic [4:0]      dst;
    logic            wr, hlt;
  } mem_wb_t;

  function automatic ctl_t decode(input logic [31:0] ir);
    ctl_t c;
    c     = '0;
    c.op  = ir[31:26];
    c.rs  = ir[25:21];
    c.rt  = ir[20:16];
    c.dst = ir[20:16];
    case (ir[31:26])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        c.dst = ir[15:11]; c.wr = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1;
      end
      OP_LW:                     begin c.wr = 1'b1; c.ld = 1'b1; c.use_rs = 1'b1; end
      OP_SW:                     begin c.st = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1; end
      OP_ADDI, OP_SUBI, OP_SLTI: begin c.wr = 1'b1; c.use_rs = 1'b1; end
      OP_BNEQZ, OP_BEQZ:         begin c.br = 1'b1; c.use_rs = 1'b1; end
      default:                   c.hlt = 1'b1;
    endcase
    return c;
  endfunction

  logic [XLEN-1:0] regs [NREG];
  logic [PC_W-1:0] pc, ifid_npc;
  logic [31:0]     ifid_ir;
  logic [3:0]      vld_pipe;  // [0]=IF/ID [1]=ID/EX [2]=EX/MEM [3]=MEM/WB
  logic            fetch_stop;
  id_ex_t          de;
  ex_mem_t         em;
  mem_wb_t         mw;

  ctl_t            id_ctl;
  logic [XLEN-1:0] id_a, id_b, ex_a, ex_b, alu;
  logic            em_fwd_ok, mw_fwd_ok, wb_we, load_use, id_hlt, br_taken;
  logic [PC_W-1:0] br_target;

  assign id_ctl    = decode(ifid_ir);
  assign em_fwd_ok = vld_pipe[2] & em.wr & ~em.ld & (em.dst != 5'd0);
  assign mw_fwd_ok = vld_pipe[3] & mw.wr & (mw.dst != 5'd0);
  assign wb_we     = mw_fwd_ok & ~halted;

  // Register read is write-first against the instruction retiring this cycle.
  assign id_a = (id_ctl.rs == 5'd0) ? '0 : (wb_we && mw.dst == id_ctl.rs) ? mw.res : regs[id_ctl.rs];
  assign id_b = (id_ctl.rt == 5'd0) ? '0 : (wb_we && mw.dst == id_ctl.rt) ? mw.res : regs[id_ctl.rt];

  assign load_use = vld_pipe[0] & vld_pipe[1] & de.ld & (de.dst != 5'd0) &
                    ((id_ctl.use_rs & (id_ctl.rs == de.dst)) | (id_ctl.use_rt & (id_ctl.rt == de.dst)));
  assign id_hlt   = vld_pipe[0] & id_ctl.hlt;

  always_comb begin
    ex_a = de.a;
    if (em_fwd_ok && em.dst == de.rs)      ex_a = em.alu;
    else if (mw_fwd_ok && mw.dst == de.rs) ex_a = mw.res;
    ex_b = de.b;
    if (em_fwd_ok && em.dst == de.rt)      ex_b = em.alu;
    else if (mw_fwd_ok && mw.dst == de.rt) ex_b = mw.res;
  end

  always_comb begin
    alu = '0;
    case (de.op)
      OP_ADD:                alu = ex_a + ex_b;
      OP_SUB:                alu = ex_a - ex_b;
      OP_AND:                alu = ex_a & ex_b;
      OP_OR:                 alu = ex_a | ex_b;
      OP_SLT:                alu = {{(XLEN-1){1'b0}}, $signed(ex_a) < $signed(ex_b)};
      OP_MUL:                alu = ex_a * ex_b;
      OP_LW, OP_SW, OP_ADDI: alu = ex_a + de.imm;
      OP_SUBI:               alu = ex_a - de.imm;
      OP_SLTI:               alu = {{(XLEN-1){1'b0}}, $signed(ex_a) < $signed(de.imm)};
      default:               alu = '0;
    endcase
  end

  assign br_target = de.npc + de.imm[PC_W-1:0];
  assign br_taken  = vld_pipe[1] & de.br & ((de.op == OP_BEQZ) ? (ex_a == '0) : (ex_a != '0));

  assign imem_addr  = pc;
  assign dmem_addr  = em.alu[PC_W-1:0];
  assign dmem_wdata = em.b;
  assign dmem_we    = vld_pipe[2] & em.st & ~halted;
  assign wb_valid   = vld_pipe[3] & ~halted;
  assign dbg_rdata  = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      ifid_ir    <= '0;
      ifid_npc   <= '0;
      vld_pipe   <= '0;
      fetch_stop <= 1'b0;
      halted     <= 1'b0;
      de         <= '0;
      em         <= '0;
      mw         <= '0;
    end else if (!halted) begin
      halted      <= vld_pipe[3] & mw.hlt;
      vld_pipe[3] <= vld_pipe[2];
      mw.res      <= em.ld ? dmem_rdata : em.alu;
      mw.dst      <= em.dst;
      mw.wr       <= em.wr;
      mw.hlt      <= em.hlt;

      vld_pipe[2] <= vld_pipe[1];
      em.alu      <= alu;
      em.b        <= ex_b;
      em.dst      <= de.dst;
      em.wr       <= de.wr;
      em.ld       <= de.ld;
      em.st       <= de.st;
      em.hlt      <= de.hlt;

      vld_pipe[1] <= vld_pipe[0] & ~load_use & ~br_taken;
      de.op       <= id_ctl.op;
      de.rs       <= id_ctl.rs;
      de.rt       <= id_ctl.rt;
      de.dst      <= id_ctl.dst;
      de.wr       <= id_ctl.wr;
      de.ld       <= id_ctl.ld;
      de.st       <= id_ctl.st;
      de.br       <= id_ctl.br;
      de.hlt      <= id_ctl.hlt;
      de.npc      <= ifid_npc;
      de.a        <= id_a;
      de.b        <= id_b;
      de.imm      <= {{(XLEN-16){ifid_ir[15]}}, ifid_ir[15:0]};

      // Flush beats stall; a HLT leaving ID freezes fetch for good.
      if (br_taken) begin
        pc          <= br_target;
        vld_pipe[0] <= 1'b0;
      end else if (load_use) begin
        pc          <= pc;
      end else if (fetch_stop || id_hlt) begin
        fetch_stop  <= 1'b1;
        vld_pipe[0] <= 1'b0;
      end else begin
        pc          <= pc + 1'b1;
        ifid_ir     <= imem_rdata;
        ifid_npc    <= pc + 1'b1;
        vld_pipe[0] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[mw.dst] <= mw.res;
    end
  end
endmodule

// File: tb/tb_pipe_mips32_fwd.sv
// Bench for pipe_mips32_fwd: directed programs plus random programs checked
// against an instruction-level model of the ISA.
module tb_pipe_mips32_fwd;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  imem_addr, dmem_addr;
  logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, dbg_rdata;
  logic        dmem_we, halted, wb_valid;
  logic [4:0]  dbg_raddr = 5'd0;

  logic [31:0] imem [1024];
  logic [31:0] dmem [1024];
  logic [31:0] dmem_init [1024];
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [1024];
  int vectors = 0, miscompares = 0;

  localparam logic [31:0] HLT = 32'hFC00_0000;

  pipe_mips32_fwd dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
    .halted(halted), .wb_valid(wb_valid), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;
  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];
  always @(posedge clk) if (dmem_we) dmem[dmem_addr] = dmem_wdata;

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd, rs, rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt, rs,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) begin
      imem[i] = HLT;
      dmem_init[i] = 32'd0;
    end
  endtask

  // Architectural reference: executes one instruction at a time until HLT/illegal.
  task automatic model_run(output int retired);
    logic [9:0]  pc;
    logic [31:0] ir, a, b, imm, res, ea;
    logic [4:0]  dst;
    logic        wr, done;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    for (int i = 0; i < 1024; i++) m_mem[i] = dmem_init[i];
    pc = 10'd0; retired = 0; done = 1'b0;
    for (int s = 0; s < 5000 && !done; s++) begin
      ir  = imem[pc];
      retired++;
      a   = m_reg[ir[25:21]];
      b   = m_reg[ir[20:16]];
      imm = {{16{ir[15]}}, ir[15:0]};
      ea  = a + imm;
      res = 32'd0; wr = 1'b0; dst = ir[20:16];
      pc  = pc + 10'd1;
      case (ir[31:26])
        6'h00: begin res = a + b; wr = 1'b1; dst = ir[15:11]; end
        6'h01: begin res = a - b; wr = 1'b1; dst = ir[15:11]; end
        6'h02: begin res = a & b; wr = 1'b1; dst = ir[15:11]; end
        6'h03: begin res = a | b; wr = 1'b1; dst = ir[15:11]; end
        6'h04: begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; wr = 1'b1; dst = ir[15:11]; end
        6'h05: begin res = a * b; wr = 1'b1; dst = ir[15:11]; end
        6'h08: begin res = m_mem[ea[9:0]]; wr = 1'b1; end
        6'h09: m_mem[ea[9:0]] = b;
        6'h0A: begin res = a + imm; wr = 1'b1; end
        6'h0B: begin res = a - imm; wr = 1'b1; end
        6'h0C: begin res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0; wr = 1'b1; end
        6'h0D: if (a != 32'd0) pc = pc + imm[9:0];
        6'h0E: if (a == 32'd0) pc = pc + imm[9:0];
        default: done = 1'b1;
      endcase
      if (wr && dst != 5'd0) m_reg[dst] = res;
    end
  endtask

  task automatic start_prog();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 1024; i++) dmem[i] = dmem_init[i];
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // cyc = rising edges after reset release until halted is seen.
  task automatic wait_halt(input int max_cyc, output int cyc, output int ret, output int bub);
    int first, last;
    cyc = 0; ret = 0; first = -1; last = -1;
    while (cyc < max_cyc) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (halted) break;
      if (wb_valid) begin
        ret++;
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    bub = (first < 0) ? 0 : (last - first + 1 - ret);
    vectors++;
    if (!halted) begin
      miscompares++;
      $display("FAIL halt_timeout: halted=%0b after %0d cycles, required 1", halted, cyc);
    end
  endtask

  task automatic get_reg(input logic [4:0] r, output logic [31:0] v);
    dbg_raddr = r;
    #1;
    v = dbg_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    get_reg(5'd3, v);
    vectors++;
    if (imem_addr !== 10'd0 || halted !== 1'b0 || wb_valid !== 1'b0 || dmem_we !== 1'b0 || v !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: pc=%0h halted=%b wb_valid=%b we=%b r3=%0h, required all 0",
               imem_addr, halted, wb_valid, dmem_we, v);
    end
  endtask

  task automatic load_prog1();
    clear_prog();
    imem[0] = enc_i(6'h0A, 5'd1, 5'd0, 16'd10);
    imem[1] = enc_i(6'h0A, 5'd2, 5'd0, 16'd20);
    imem[2] = enc_r(6'h00, 5'd3, 5'd1, 5'd2);
    imem[3] = HLT;
  endtask

  task automatic test_fwd_basic();
    int cyc, ret, bub;
    logic [31:0] v;
    load_prog1();
    start_prog();
    wait_halt(200, cyc, ret, bub);
    get_reg(5'd3, v);
    vectors++;
    if (v !== 32'd30) begin miscompares++; $display("FAIL basic_r3: got %0d, required 30", v); end
    vectors++;
    if (cyc != 8) begin miscompares++; $display("FAIL basic_halt_cycle: got %0d, required 8", cyc); end
    vectors++;
    if (ret != 4 || bub != 0) begin
      miscompares++; $display("FAIL basic_retire: retired=%0d bubbles=%0d, required 4/0", ret, bub);
    end
  endtask

  task automatic test_load_use();
    int cyc, ret, bub;
    logic [31:0] v;
    clear_prog();
    imem[0] = enc_i(6'h0A, 5'd1, 5'd0, 16'd7);
    imem[1] = enc_i(6'h09, 5'd1, 5'd0, 16'd5);
    imem[2] = enc_i(6'h08, 5'd2, 5'd0, 16'd5);
    imem[3] = enc_r(6'h00, 5'd3, 5'd2, 5'd2);
    imem[4] = HLT;
    start_prog();
    wait_halt(200, cyc, ret, bub);
    get_reg(5'd3, v);
    vectors++;
    if (v !== 32'd14) begin miscompares++; $display("FAIL load_use_r3: got %0d, required 14", v); end
    vectors++;
    if (dmem[5] !== 32'd7) begin miscompares++; $display("FAIL load_use_dmem5: got %0d, required 7", dmem[5]); end
    vectors++;
    if (bub != 1 || ret != 5) begin
      miscompares++; $display("FAIL load_use_bubbles: bubbles=%0d retired=%0d, required 1/5", bub, ret);
    end
  endtask

  task automatic test_branch_flush();
    int cyc, ret, bub;
    logic [31:0] r4, r5, r6;
    clear_prog();
    imem[0] = enc_i(6'h0E, 5'd0, 5'd0, 16'd2);
    imem[1] = enc_i(6'h0A, 5'd4, 5'd0, 16'd1);
    imem[2] = enc_i(6'h0A, 5'd5, 5'd0, 16'd1);
    imem[3] = enc_i(6'h0A, 5'd6, 5'd0, 16'd9);
    imem[4] = HLT;
    start_prog();
    wait_halt(200, cyc, ret, bub);
    get_reg(5'd4, r4);
    get_reg(5'd5, r5);
    get_reg(5'd6, r6);
    vectors++;
    if (r4 !== 32'd0 || r5 !== 32'd0 || r6 !== 32'd9) begin
      miscompares++; $display("FAIL branch_regs: r4=%0d r5=%0d r6=%0d, required 0/0/9", r4, r5, r6);
    end
    vectors++;
    if (ret != 3) begin miscompares++; $display("FAIL branch_retire: got %0d, required 3", ret); end
  endtask

  task automatic test_loop();
    int cyc, ret, bub;
    logic [31:0] r1, r2;
    clear_prog();
    imem[0] = enc_i(6'h0A, 5'd1, 5'd0, 16'd3);
    imem[1] = enc_i(6'h0B, 5'd1, 5'd1, 16'd1);
    imem[2] = enc_i(6'h0A, 5'd2, 5'd2, 16'd2);
    imem[3] = enc_i(6'h0D, 5'd0, 5'd1, 16'hFFFD);
    imem[4] = HLT;
    start_prog();
    wait_halt(300, cyc, ret, bub);
    get_reg(5'd1, r1);
    get_reg(5'd2, r2);
    vectors++;
    if (r1 !== 32'd0 || r2 !== 32'd6) begin
      miscompares++; $display("FAIL loop_regs: r1=%0d r2=%0d, required 0/6", r1, r2);
    end
    vectors++;
    if (ret != 11) begin miscompares++; $display("FAIL loop_retire: got %0d, required 11", ret); end
  endtask

  task automatic test_illegal_halt();
    int cyc, ret, bub;
    logic [31:0] r1;
    clear_prog();
    imem[0] = enc_i(6'h0A, 5'd1, 5'd0, 16'd4);
    imem[1] = 32'hF800_0000;
    imem[2] = enc_i(6'h0A, 5'd1, 5'd0, 16'd9);
    start_prog();
    wait_halt(200, cyc, ret, bub);
    vectors++;
    if (ret != 2) begin miscompares++; $display("FAIL illegal_retire: got %0d, required 2", ret); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (imem_addr !== 10'd2 || halted !== 1'b1 || wb_valid !== 1'b0 || dmem_we !== 1'b0) begin
        miscompares++;
        $display("FAIL halted_stable: pc=%0d halted=%b wb_valid=%b we=%b, required 2/1/0/0",
                 imem_addr, halted, wb_valid, dmem_we);
      end
    end
    get_reg(5'd1, r1);
    vectors++;
    if (r1 !== 32'd4) begin miscompares++; $display("FAIL illegal_r1: got %0d, required 4", r1); end
  endtask

  task automatic test_reset_mid();
    int cyc, ret, bub;
    logic [31:0] v;
    load_prog1();
    start_prog();
    repeat (6) @(negedge clk);
    get_reg(5'd1, v);
    vectors++;
    if (v !== 32'd10) begin miscompares++; $display("FAIL mid_pre_r1: got %0d, required 10", v); end
    rst_n = 1'b0;
    get_reg(5'd1, v);
    vectors++;
    if (imem_addr !== 10'd0 || wb_valid !== 1'b0 || halted !== 1'b0 || dmem_we !== 1'b0 || v !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_reset_state: pc=%0d wb_valid=%b halted=%b we=%b r1=%0d, required all 0",
               imem_addr, wb_valid, halted, dmem_we, v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_halt(200, cyc, ret, bub);
    get_reg(5'd3, v);
    vectors++;
    if (v !== 32'd30 || cyc != 8) begin
      miscompares++; $display("FAIL mid_rerun: r3=%0d halt_cycle=%0d, required 30/8", v, cyc);
    end
  endtask

  task automatic test_random();
    int cyc, ret, bub, m_ret, len, k, off, bad;
    logic [31:0] v;
    logic [4:0]  ra, rb, rc;
    for (int p = 0; p < 10; p++) begin
      clear_prog();
      for (int i = 0; i < 16; i++) dmem_init[i] = $urandom;
      len = $urandom_range(10, 24);
      for (int i = 0; i < len; i++) begin
        k  = $urandom_range(0, 13);
        ra = 5'($urandom_range(0, 7));
        rb = 5'($urandom_range(0, 7));
        rc = 5'($urandom_range(0, 7));
        case (k)
          0, 1, 2, 3, 4, 5: imem[i] = enc_r(6'(k), ra, rb, rc);
          6:      imem[i] = enc_i(6'h0A, ra, rb, 16'($urandom_range(0, 65535)));
          7:      imem[i] = enc_i(6'h0B, ra, rb, 16'($urandom_range(0, 65535)));
          8:      imem[i] = enc_i(6'h0C, ra, rb, 16'($urandom_range(0, 65535)));
          9, 10:  imem[i] = enc_i(6'h08, ra, rb, 16'($urandom_range(0, 15)));
          11:     imem[i] = enc_i(6'h09, ra, rb, 16'($urandom_range(0, 15)));
          default: begin
            off = $urandom_range(0, 3);
            if (off > len - 1 - i) off = len - 1 - i;
            imem[i] = enc_i((k == 12) ? 6'h0D : 6'h0E, 5'd0, rb, 16'(off));
          end
        endcase
      end
      imem[len] = HLT;
      model_run(m_ret);
      start_prog();
      wait_halt(2000, cyc, ret, bub);
      vectors++;
      if (ret != m_ret) begin
        miscompares++; $display("FAIL rand%0d_retire: got %0d, required %0d", p, ret, m_ret);
      end
      for (int r = 1; r < 8; r++) begin
        get_reg(5'(r), v);
        vectors++;
        if (v !== m_reg[r]) begin
          miscompares++; $display("FAIL rand%0d_r%0d: got %h, required %h", p, r, v, m_reg[r]);
        end
      end
      bad = 0;
      for (int i = 0; i < 1024; i++) if (dmem[i] !== m_mem[i]) bad++;
      vectors++;
      if (bad != 0) begin
        miscompares++; $display("FAIL rand%0d_dmem: %0d words differ, required 0", p, bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fwd_basic();
    test_load_use();
    test_branch_flush();
    test_loop();
    test_illegal_halt();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
